grid_player_mover: RTL and testbench
====================================

GRID_PLAYER_MOVER -- requirements
Module: grid_player_mover

Interface
REQ-001 SHALL have parameter COLS, default 5, grid columns (2..16).
REQ-002 SHALL have parameter ROWS, default 5, grid rows (2..16).
REQ-003 SHALL have parameter WRAP, default 0: 0 = clamp at edges, 1 = wrap to the opposite edge.
REQ-004 SHALL have parameter HOLD_DELAY, default 12, cycles from the first move to the first auto-repeat (>=2).
REQ-005 SHALL have parameter REPEAT_PERIOD, default 4, cycles between auto-repeats (>=1).
REQ-006 SHALL have port clk input 1, clock.
REQ-007 SHALL have port reset input 1, asynchronous, active-high reset.
REQ-008 SHALL have ports up, down, left, right, each input 1, level direction requests.
REQ-009 SHALL have port blocked input COLS*ROWS, obstacle mask; bit row*COLS+col set = cell impassable.
REQ-010 SHALL have port grid_starting_x input 8, pixel x of cell (0,0).
REQ-011 SHALL have port grid_starting_y input 7, pixel y of cell (0,0).
REQ-012 SHALL have port grid_size input 5, cell pitch in pixels.
REQ-013 SHALL have port col output 4, current column.
REQ-014 SHALL have port row output 4, current row.
REQ-015 SHALL have port x output 8, pixel x of the current cell.
REQ-016 SHALL have port y output 7, pixel y of the current cell.
REQ-017 SHALL have port moved output 1, one-cycle pulse on each accepted move.
REQ-018 SHALL have port bump output 1, one-cycle pulse on each rejected move attempt.

Function
REQ-019 SHALL resolve the active direction by fixed priority up > down > left > right; lower-priority requests are ignored that cycle.
REQ-020 SHALL implement FSM IDLE / DELAY / REPEAT: IDLE -> DELAY on an active direction; DELAY -> REPEAT after HOLD_DELAY cycles; any state -> IDLE when no direction is active.
REQ-021 SHALL attempt a move at the first clock edge a direction is sampled active from IDLE (attempt cycle t).
REQ-022 SHALL, while the same direction is held, attempt further moves at t+HOLD_DELAY, then every REPEAT_PERIOD cycles thereafter.
REQ-023 SHALL treat a change of resolved direction while held as a new press: attempt at that edge and restart DELAY.
REQ-024 SHALL, on an attempt, compute the target cell: up row-1, down row+1, left col-1, right col+1.
REQ-025 SHALL, with WRAP=0, reject an attempt whose target lies outside 0..COLS-1 / 0..ROWS-1 (col/row unchanged, bump=1).
REQ-026 SHALL, with WRAP=1, map an out-of-range target to the opposite edge (col 0 left -> COLS-1; row ROWS-1 down -> 0).
REQ-027 SHALL reject an attempt whose (wrapped) target has its blocked bit set (bump=1, no move).
REQ-028 SHALL, on an accepted attempt, update col/row at that edge and assert moved for exactly that cycle.
REQ-029 SHALL never assert moved and bump in the same cycle; rejected auto-repeats also pulse bump.
REQ-030 SHALL drive x = grid_starting_x + col*grid_size and y = grid_starting_y + row*grid_size combinationally, truncated modulo 2^8 / 2^7.
REQ-031 SHALL not re-check the current cell against blocked (a player standing on a newly blocked cell stays).

Reset
REQ-032 SHALL, on reset, asynchronously set col=COLS/2, row=ROWS/2 (integer division), FSM=IDLE, repeat counter=0, moved=0, bump=0.
REQ-033 SHALL, after reset deasserts with a direction still held, treat it as a new press at the first sampled edge.

Verification
REQ-034 SHALL cover: COLS=ROWS=5, start (40,20), size 10, reset -> col=2, row=2, x=60, y=40, moved=0, bump=0.
REQ-035 SHALL cover: one-cycle up pulse from (2,2) -> row=1, y=30, moved high one cycle; up+left together -> only row changes.
REQ-036 SHALL cover: WRAP=0 at row 0, up pulse -> row stays 0, bump=1; WRAP=1, same stimulus -> row=4, y=60, moved=1.
REQ-037 SHALL cover: HOLD_DELAY=4, REPEAT_PERIOD=2, right held from (0,2) -> moves at t, t+4, t+6, t+8 reaching col 4, then bump at t+10, t+12 (WRAP=0).
REQ-038 SHALL cover: blocked bit 13 set (col 3, row 2), right from (2,2) -> col stays 2, bump=1; clear bit, right again -> col=3.
REQ-039 SHALL cover: reset asserted mid-REPEAT with right held -> immediate return to (2,2), no pulses during reset, fresh move at first edge after release.

Source files
------------

// File: rtl/grid_player_mover.sv
// grid_player_mover
//
// Moves a player marker around a COLS x ROWS grid from four level-sensitive
// direction requests. A fresh press moves once right away. Holding the same
// direction repeats the move after HOLD_DELAY cycles, then every
// REPEAT_PERIOD cycles. A move that would leave the grid (WRAP=0) or land on
// a blocked cell is rejected with a bump pulse. With WRAP=1 the player
// reappears at the opposite edge instead.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   up/down/left/right    level direction requests (priority up>down>left>right)
//   blocked               obstacle mask, bit row*COLS+col set = impassable
//   grid_starting_x/_y    pixel position of cell (0,0)
//   grid_size             cell pitch in pixels
//   col, row              current cell
//   x, y                  pixel position of the current cell (combinational)
//   moved, bump           one-cycle pulses for accepted / rejected attempts

module grid_player_mover #(
  parameter int COLS          = 5,
  parameter int ROWS          = 5,
  parameter int WRAP          = 0,
  parameter int HOLD_DELAY    = 12,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 up,
  input  logic                 down,
  input  logic                 left,
  input  logic                 right,
  input  logic [COLS*ROWS-1:0] blocked,
  input  logic [7:0]           grid_starting_x,
  input  logic [6:0]           grid_starting_y,
  input  logic [4:0]           grid_size,
  output logic [3:0]           col,
  output logic [3:0]           row,
  output logic [7:0]           x,
  output logic [6:0]           y,
  output logic                 moved,
  output logic                 bump
);

  localparam int NCELL   = COLS * ROWS;
  localparam int CNT_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HOLD_C   = CW'(HOLD_DELAY);
  localparam logic [CW-1:0] REPEAT_C = CW'(REPEAT_PERIOD);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    COL_MAX  = 4'(COLS - 1);
  localparam logic [3:0]    ROW_MAX  = 4'(ROWS - 1);
  localparam logic [3:0]    COL_HOME = 4'(COLS / 2);
  localparam logic [3:0]    ROW_HOME = 4'(ROWS / 2);

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } state_t;

  state_t          r_state;
  dir_t            r_dir;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_col;
  logic [3:0]      r_row;
  logic            r_moved;
  logic            r_bump;

  logic            w_dirValid;
  dir_t            w_dir;
  logic [3:0]      w_tgtCol;
  logic [3:0]      w_tgtRow;
  logic            w_offGrid;
  logic [7:0]      w_idx;
  logic [NCELL-1:0] w_cellMask;
  logic            w_tgtBlocked;
  logic            w_reject;
  logic            w_newPress;
  logic            w_attempt;

  // Resolve the four requests into a single direction by fixed priority.
  always_comb begin
    w_dirValid = up | down | left | right;
    w_dir      = DIR_RIGHT;
    if (up)        w_dir = DIR_UP;
    else if (down) w_dir = DIR_DOWN;
    else if (left) w_dir = DIR_LEFT;
  end

  // Target cell for the resolved direction. Stepping past an edge either
  // wraps to the opposite edge or flags the attempt as off-grid.
  always_comb begin
    w_tgtCol  = r_col;
    w_tgtRow  = r_row;
    w_offGrid = 1'b0;
    case (w_dir)
      DIR_UP: begin
        if (r_row == 4'd0) begin
          w_tgtRow  = ROW_MAX;
          w_offGrid = (WRAP == 0);
        end else begin
          w_tgtRow = r_row - 4'd1;
        end
      end
      DIR_DOWN: begin
        if (r_row == ROW_MAX) begin
          w_tgtRow  = 4'd0;
          w_offGrid = (WRAP == 0);
        end else begin
          w_tgtRow = r_row + 4'd1;
        end
      end
      DIR_LEFT: begin
        if (r_col == 4'd0) begin
          w_tgtCol  = COL_MAX;
          w_offGrid = (WRAP == 0);
        end else begin
          w_tgtCol = r_col - 4'd1;
        end
      end
      DIR_RIGHT: begin
        if (r_col == COL_MAX) begin
          w_tgtCol  = 4'd0;
          w_offGrid = (WRAP == 0);
        end else begin
          w_tgtCol = r_col + 4'd1;
        end
      end
    endcase
  end

  // Obstacle lookup on the (possibly wrapped) target. A one-hot mask avoids
  // a variable part-select whose index width would not match the mask.
  assign w_idx        = 8'(w_tgtRow) * 8'(COLS) + 8'(w_tgtCol);
  assign w_cellMask   = {{(NCELL-1){1'b0}}, 1'b1} << w_idx;
  assign w_tgtBlocked = |(blocked & w_cellMask);
  assign w_reject     = w_offGrid | w_tgtBlocked;

  // Decide whether this edge is a move attempt. A direction change while
  // held counts as a new press, exactly like a press from IDLE.
  always_comb begin
    w_newPress = w_dirValid && ((r_state == S_IDLE) || (w_dir != r_dir));
    w_attempt  = 1'b0;
    if (w_dirValid) begin
      if (w_newPress)               w_attempt = 1'b1;
      else if (r_state == S_DELAY)  w_attempt = (r_cnt == HOLD_C);
      else                          w_attempt = (r_cnt == REPEAT_C);
    end
  end

  // Hold/repeat FSM plus position and pulse registers. r_cnt counts cycles
  // since the last attempt, so it reads 1 on the edge after an attempt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_dir   <= DIR_UP;
      r_cnt   <= '0;
      r_col   <= COL_HOME;
      r_row   <= ROW_HOME;
      r_moved <= 1'b0;
      r_bump  <= 1'b0;
    end else begin
      r_moved <= 1'b0;
      r_bump  <= 1'b0;

      if (!w_dirValid) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else if (w_newPress) begin
        r_state <= S_DELAY;
        r_dir   <= w_dir;
        r_cnt   <= CNT_ONE;
      end else if (w_attempt) begin
        r_state <= S_REPEAT;
        r_cnt   <= CNT_ONE;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end

      if (w_attempt) begin
        if (w_reject) begin
          r_bump <= 1'b1;
        end else begin
          r_col   <= w_tgtCol;
          r_row   <= w_tgtRow;
          r_moved <= 1'b1;
        end
      end
    end
  end

  assign col   = r_col;
  assign row   = r_row;
  assign moved = r_moved;
  assign bump  = r_bump;

  // Pixel position wraps naturally in the output widths.
  assign x = grid_starting_x + (8'(r_col) * 8'(grid_size));
  assign y = grid_starting_y + (7'(r_row) * 7'(grid_size));

endmodule

// File: tb/tb_grid_player_mover.sv
// tb_grid_player_mover
//
// Two instances share clock, reset, obstacle mask and pixel geometry on a
// 5x5 grid starting at (40,20) with pitch 10. Instance A clamps at the edges,
// instance B wraps; both use a short hold delay of 4 and repeat period of 2.
// Each task drives its own direction requests, pushes the expected state
// into a queue when it drives, and pops it after the following clock edge.

module tb_grid_player_mover;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        aUp = 1'b0, aDown = 1'b0, aLeft = 1'b0, aRight = 1'b0;
  logic        bUp = 1'b0, bDown = 1'b0, bLeft = 1'b0, bRight = 1'b0;
  logic [24:0] blocked = '0;
  logic [7:0]  gsx = 8'd40;
  logic [6:0]  gsy = 7'd20;
  logic [4:0]  gsz = 5'd10;

  logic [3:0]  aCol, aRow, bCol, bRow;
  logic [7:0]  aX, bX;
  logic [6:0]  aY, bY;
  logic        aMoved, aBump, bMoved, bBump;

  typedef struct {
    logic [3:0] col;
    logic [3:0] row;
    logic [7:0] x;
    logic [6:0] y;
    logic       moved;
    logic       bump;
  } exp_t;

  exp_t expQ[$];
  exp_t expQB[$];
  int   total = 0;
  int   bad   = 0;

  grid_player_mover #(
    .COLS(5), .ROWS(5), .WRAP(0), .HOLD_DELAY(4), .REPEAT_PERIOD(2)
  ) dutA (
    .clk(clk), .reset(reset),
    .up(aUp), .down(aDown), .left(aLeft), .right(aRight),
    .blocked(blocked),
    .grid_starting_x(gsx), .grid_starting_y(gsy), .grid_size(gsz),
    .col(aCol), .row(aRow), .x(aX), .y(aY),
    .moved(aMoved), .bump(aBump)
  );

  grid_player_mover #(
    .COLS(5), .ROWS(5), .WRAP(1), .HOLD_DELAY(4), .REPEAT_PERIOD(2)
  ) dutB (
    .clk(clk), .reset(reset),
    .up(bUp), .down(bDown), .left(bLeft), .right(bRight),
    .blocked(blocked),
    .grid_starting_x(gsx), .grid_starting_y(gsy), .grid_size(gsz),
    .col(bCol), .row(bRow), .x(bX), .y(bY),
    .moved(bMoved), .bump(bBump)
  );

  always #5 clk = ~clk;

  // Expected outputs for a cell; pixel position from the fixed geometry.
  function automatic exp_t mkExp(input int c, input int r, input logic m, input logic b);
    exp_t e;
    e.col   = 4'(c);
    e.row   = 4'(r);
    e.x     = 8'(40 + c * 10);
    e.y     = 7'(20 + r * 10);
    e.moved = m;
    e.bump  = b;
    return e;
  endfunction

  task automatic setA(input logic [3:0] d);
    {aUp, aDown, aLeft, aRight} = d;
  endtask

  task automatic pulseReset;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reset values on both instances: home cell (2,2) at pixel (60,40).
  task automatic test_reset;
    exp_t e;
    reset = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk);
    expQ.push_back(mkExp(2, 2, 1'b0, 1'b0));
    expQB.push_back(mkExp(2, 2, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    total++;
    if ({aCol, aRow, aX, aY, aMoved, aBump} !== {e.col, e.row, e.x, e.y, e.moved, e.bump}) begin
      bad++;
      $display("[TB] FAIL reset_a: got col=%0d row=%0d x=%0d y=%0d moved=%b bump=%b, want col=%0d row=%0d x=%0d y=%0d moved=%b bump=%b",
               aCol, aRow, aX, aY, aMoved, aBump, e.col, e.row, e.x, e.y, e.moved, e.bump);
    end
    e = expQB.pop_front();
    total++;
    if ({bCol, bRow, bX, bY, bMoved, bBump} !== {e.col, e.row, e.x, e.y, e.moved, e.bump}) begin
      bad++;
      $display("[TB] FAIL reset_b: got col=%0d row=%0d x=%0d y=%0d moved=%b bump=%b, want col=%0d row=%0d x=%0d y=%0d moved=%b bump=%b",
               bCol, bRow, bX, bY, bMoved, bBump, e.col, e.row, e.x, e.y, e.moved, e.bump);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Single-cycle pulses and priority resolution, starting from (2,2).
  // Direction bits are {up, down, left, right}.
  task automatic test_pulse_priority;
    exp_t e;
    logic [3:0] dirs [8];
    int         ec [8];
    int         er [8];
    logic       em [8];
    dirs = '{4'b1000, 4'b0000, 4'b1010, 4'b0000, 4'b0101, 4'b0000, 4'b1000, 4'b0000};
    ec   = '{2, 2, 2, 2, 2, 2, 2, 2};
    er   = '{1, 1, 0, 0, 1, 1, 0, 0};
    em   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      setA(dirs[i]);
      expQ.push_back(mkExp(ec[i], er[i], em[i], 1'b0));
      @(posedge clk);
      #1;
      e = expQ.pop_front();
      total++;
      if ({aCol, aRow, aX, aY, aMoved, aBump} !== {e.col, e.row, e.x, e.y, e.moved, e.bump}) begin
        bad++;
        $display("[TB] FAIL pulse_step%0d: got col=%0d row=%0d x=%0d y=%0d moved=%b bump=%b, want col=%0d row=%0d x=%0d y=%0d moved=%b bump=%b",
                 i, aCol, aRow, aX, aY, aMoved, aBump, e.col, e.row, e.x, e.y, e.moved, e.bump);
      end
    end
  endtask

  // Top edge: A (at row 0) clamps and bumps; B walks up from row 2 and
  // wraps to row 4, then wraps back down to row 0.
  task automatic test_clamp_wrap;
    exp_t e;
    logic [3:0] bdirs [8];
    int         br [8];
    logic       bm [8];
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      setA(i == 0 ? 4'b1000 : 4'b0000);
      expQ.push_back(mkExp(2, 0, 1'b0, i == 0));
      @(posedge clk);
      #1;
      e = expQ.pop_front();
      total++;
      if ({aCol, aRow, aX, aY, aMoved, aBump} !== {e.col, e.row, e.x, e.y, e.moved, e.bump}) begin
        bad++;
        $display("[TB] FAIL clamp_step%0d: got col=%0d row=%0d x=%0d y=%0d moved=%b bump=%b, want col=%0d row=%0d x=%0d y=%0d moved=%b bump=%b",
                 i, aCol, aRow, aX, aY, aMoved, aBump, e.col, e.row, e.x, e.y, e.moved, e.bump);
      end
    end
    bdirs = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0100, 4'b0000};
    br    = '{1, 1, 0, 0, 4, 4, 0, 0};
    bm    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {bUp, bDown, bLeft, bRight} = bdirs[i];
      expQB.push_back(mkExp(2, br[i], bm[i], 1'b0));
      @(posedge clk);
      #1;
      e = expQB.pop_front();
      total++;
      if ({bCol, bRow, bX, bY, bMoved, bBump} !== {e.col, e.row, e.x, e.y, e.moved, e.bump}) begin
        bad++;
        $display("[TB] FAIL wrap_step%0d: got col=%0d row=%0d x=%0d y=%0d moved=%b bump=%b, want col=%0d row=%0d x=%0d y=%0d moved=%b bump=%b",
                 i, bCol, bRow, bX, bY, bMoved, bBump, e.col, e.row, e.x, e.y, e.moved, e.bump);
      end
    end
  endtask

  // Right held from (0,2): moves at t, t+4, t+6, t+8, then bumps at the
  // right edge every 2 cycles; releasing returns to quiet.
  task automatic test_hold_repeat;
    exp_t e;
    int   expCol;
    logic m;
    logic b;
    pulseReset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      setA(i % 2 == 0 ? 4'b0010 : 4'b0000);
      expQ.push_back(mkExp(1 - i / 2, 2, i % 2 == 0, 1'b0));
      @(posedge clk);
      #1;
      e = expQ.pop_front();
      total++;
      if ({aCol, aRow, aX, aY, aMoved, aBump} !== {e.col, e.row, e.x, e.y, e.moved, e.bump}) begin
        bad++;
        $display("[TB] FAIL hold_setup%0d: got col=%0d row=%0d x=%0d y=%0d moved=%b bump=%b, want col=%0d row=%0d x=%0d y=%0d moved=%b bump=%b",
                 i, aCol, aRow, aX, aY, aMoved, aBump, e.col, e.row, e.x, e.y, e.moved, e.bump);
      end
    end
    expCol = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      setA(k < 15 ? 4'b0001 : 4'b0000);
      m = (k == 0) || (k == 4) || (k == 6) || (k == 8);
      b = (k >= 10) && (k < 15) && (k % 2 == 0);
      if (m) expCol++;
      expQ.push_back(mkExp(expCol, 2, m, b));
      @(posedge clk);
      #1;
      e = expQ.pop_front();
      total++;
      if ({aCol, aRow, aX, aY, aMoved, aBump} !== {e.col, e.row, e.x, e.y, e.moved, e.bump}) begin
        bad++;
        $display("[TB] FAIL hold_t+%0d: got col=%0d row=%0d x=%0d y=%0d moved=%b bump=%b, want col=%0d row=%0d x=%0d y=%0d moved=%b bump=%b",
                 k, aCol, aRow, aX, aY, aMoved, aBump, e.col, e.row, e.x, e.y, e.moved, e.bump);
      end
    end
  endtask

  // From (4,2): left press, then switch to up while held. The switch moves
  // immediately and restarts the hold delay; the repeat then bumps at row 0.
  task automatic test_dir_change;
    exp_t e;
    logic [3:0] dirs [10];
    int         er [10];
    logic       em [10];
    logic       eb [10];
    dirs = '{4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
    er   = '{2, 2, 1, 1, 1, 1, 0, 0, 0, 0};
    em   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    eb   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      setA(dirs[i]);
      expQ.push_back(mkExp(3, er[i], em[i], eb[i]));
      @(posedge clk);
      #1;
      e = expQ.pop_front();
      total++;
      if ({aCol, aRow, aX, aY, aMoved, aBump} !== {e.col, e.row, e.x, e.y, e.moved, e.bump}) begin
        bad++;
        $display("[TB] FAIL dirchg_step%0d: got col=%0d row=%0d x=%0d y=%0d moved=%b bump=%b, want col=%0d row=%0d x=%0d y=%0d moved=%b bump=%b",
                 i, aCol, aRow, aX, aY, aMoved, aBump, e.col, e.row, e.x, e.y, e.moved, e.bump);
      end
    end
  endtask

  // Obstacle at (3,2) = bit 13 blocks a move from (2,2); once cleared the
  // move succeeds. Re-blocking the occupied cell does not push the player.
  task automatic test_blocked;
    exp_t e;
    logic [3:0] dirs [7];
    logic       blk [7];
    int         ec [7];
    int         er [7];
    logic       em [7];
    logic       eb [7];
    dirs = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
    blk  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    ec   = '{2, 2, 3, 3, 3, 3, 3};
    er   = '{2, 2, 2, 2, 2, 3, 3};
    em   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    eb   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    pulseReset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      setA(dirs[i]);
      blocked     = '0;
      blocked[13] = blk[i];
      expQ.push_back(mkExp(ec[i], er[i], em[i], eb[i]));
      @(posedge clk);
      #1;
      e = expQ.pop_front();
      total++;
      if ({aCol, aRow, aX, aY, aMoved, aBump} !== {e.col, e.row, e.x, e.y, e.moved, e.bump}) begin
        bad++;
        $display("[TB] FAIL blocked_step%0d: got col=%0d row=%0d x=%0d y=%0d moved=%b bump=%b, want col=%0d row=%0d x=%0d y=%0d moved=%b bump=%b",
                 i, aCol, aRow, aX, aY, aMoved, aBump, e.col, e.row, e.x, e.y, e.moved, e.bump);
      end
    end
    blocked = '0;
  endtask

  // Reset hits mid-repeat with right still held: immediate return home, no
  // pulses while held in reset, and a fresh press on the first edge after.
  task automatic test_reset_mid_repeat;
    exp_t e;
    int   expCol;
    logic m;
    pulseReset();
    expCol = 2;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      setA(4'b0001);
      m = (k == 0) || (k == 4);
      if (m) expCol++;
      expQ.push_back(mkExp(expCol, 2, m, 1'b0));
      @(posedge clk);
      #1;
      e = expQ.pop_front();
      total++;
      if ({aCol, aRow, aX, aY, aMoved, aBump} !== {e.col, e.row, e.x, e.y, e.moved, e.bump}) begin
        bad++;
        $display("[TB] FAIL rstmid_pre%0d: got col=%0d row=%0d x=%0d y=%0d moved=%b bump=%b, want col=%0d row=%0d x=%0d y=%0d moved=%b bump=%b",
                 k, aCol, aRow, aX, aY, aMoved, aBump, e.col, e.row, e.x, e.y, e.moved, e.bump);
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        reset = 1'b1;
        expQ.push_back(mkExp(2, 2, 1'b0, 1'b0));
        #1;
      end else begin
        expQ.push_back(mkExp(2, 2, 1'b0, 1'b0));
        @(posedge clk);
        #1;
      end
      e = expQ.pop_front();
      total++;
      if ({aCol, aRow, aX, aY, aMoved, aBump} !== {e.col, e.row, e.x, e.y, e.moved, e.bump}) begin
        bad++;
        $display("[TB] FAIL rstmid_in%0d: got col=%0d row=%0d x=%0d y=%0d moved=%b bump=%b, want col=%0d row=%0d x=%0d y=%0d moved=%b bump=%b",
                 k, aCol, aRow, aX, aY, aMoved, aBump, e.col, e.row, e.x, e.y, e.moved, e.bump);
      end
    end
    expCol = 2;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      reset = 1'b0;
      setA(k < 5 ? 4'b0001 : 4'b0000);
      m = (k == 0) || (k == 4);
      if (m) expCol++;
      expQ.push_back(mkExp(expCol, 2, m, 1'b0));
      @(posedge clk);
      #1;
      e = expQ.pop_front();
      total++;
      if ({aCol, aRow, aX, aY, aMoved, aBump} !== {e.col, e.row, e.x, e.y, e.moved, e.bump}) begin
        bad++;
        $display("[TB] FAIL rstmid_post%0d: got col=%0d row=%0d x=%0d y=%0d moved=%b bump=%b, want col=%0d row=%0d x=%0d y=%0d moved=%b bump=%b",
                 k, aCol, aRow, aX, aY, aMoved, aBump, e.col, e.row, e.x, e.y, e.moved, e.bump);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pulse_priority();
    test_clamp_wrap();
    test_hold_repeat();
    test_dir_change();
    test_blocked();
    test_reset_mid_repeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
